// File: rtl/button_reset_gen.sv
// ---------------------------------------------------------------------------
// button_reset_gen
//
// Turns a raw, bouncy pushbutton into a clean, fixed-width, active-low
// synchronous reset pulse for the downstream binary counter. It also exports
// the debounced button level and a one-cycle press strobe.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a change
//                     (1 .. 2**DB_W-1)
//   DB_W            - width of the debounce counter
//   RST_CYCLES      - cycles cnt_rst_n is held low per event (1 .. 255)
//
// Ports:
//   clk         in  system clock, all logic on posedge
//   rst         in  asynchronous active-low reset of this block
//   btn         in  raw pushbutton (asynchronous, bouncy, 1 = pressed)
//   cnt_rst_n   out registered active-low reset for the downstream counter
//   pressed     out debounced button level
//   press_pulse out one-cycle strobe on each accepted press (0->1)
//   busy        out high while cnt_rst_n is low
//
// Build option:
//   BTN_RST_POR_EN - when defined, reset parks the FSM in HOLD so that
//                    cnt_rst_n stays low for RST_CYCLES cycles after rst
//                    is released (power-on reset of the counter). When
//                    undefined, reset parks the FSM in IDLE.
// ---------------------------------------------------------------------------
module button_reset_gen #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int RST_CYCLES      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic cnt_rst_n,
    output logic pressed,
    output logic press_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]      HC_LAST = 8'(RST_CYCLES - 1);

`ifdef BTN_RST_POR_EN
    localparam state_t RST_STATE     = HOLD;
    localparam logic   RST_CNT_RST_N = 1'b0;
    localparam logic   RST_BUSY      = 1'b1;
`else
    localparam state_t RST_STATE     = IDLE;
    localparam logic   RST_CNT_RST_N = 1'b1;
    localparam logic   RST_BUSY      = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Two-flop synchroniser: the only place btn is sampled.
    // -----------------------------------------------------------------------
    logic btn_m;
    logic btn_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
        end
    end

    // -----------------------------------------------------------------------
    // Debouncer: counts consecutive cycles where btn_s disagrees with the
    // accepted level; any agreeing cycle restarts the count.
    // -----------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt;
    logic            db_diff;
    logic            db_done;

    always_comb begin
        db_diff = (btn_s != pressed);
        db_done = db_diff && (db_cnt == DB_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt      <= '0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            // The strobe is registered alongside the level so both rise on
            // the same edge; a release toggle produces no strobe.
            press_pulse <= db_done && !pressed;
            if (!db_diff) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_cnt  <= '0;
                pressed <= ~pressed;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reset-pulse FSM
    // -----------------------------------------------------------------------
    state_t     state;
    state_t     state_nx;
    logic [7:0] hc;
    logic [7:0] hc_nx;
    logic       cnt_rst_n_nx;
    logic       busy_nx;

    // State register; outputs are registered from the next-state decode so
    // they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RST_STATE;
            hc        <= '0;
            cnt_rst_n <= RST_CNT_RST_N;
            busy      <= RST_BUSY;
        end else begin
            state     <= state_nx;
            hc        <= hc_nx;
            cnt_rst_n <= cnt_rst_n_nx;
            busy      <= busy_nx;
        end
    end

    // Next-state decode. Presses arriving outside IDLE are ignored, so a
    // held button yields a single pulse and HOLD is never extended.
    always_comb begin
        state_nx = state;
        hc_nx    = hc;
        case (state)
            IDLE: begin
                if (press_pulse) begin
                    state_nx = HOLD;
                    hc_nx    = '0;
                end
            end
            HOLD: begin
                if (hc == HC_LAST) begin
                    state_nx = pressed ? WAIT_REL : IDLE;
                end else begin
                    hc_nx = hc + 8'd1;
                end
            end
            WAIT_REL: begin
                if (!pressed) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                hc_nx    = '0;
            end
        endcase
    end

    // Output decode from the next state.
    always_comb begin
        busy_nx      = (state_nx == HOLD);
        cnt_rst_n_nx = !(state_nx == HOLD);
    end

endmodule

// File: tb/tb_button_reset_gen.sv
// ---------------------------------------------------------------------------
// tb_button_reset_gen
//
// Directed scenarios followed by randomized button activity, with every
// cycle compared against a behavioural model of the button/reset rules.
// Honours BTN_RST_POR_EN so the same bench covers both build options.
// ---------------------------------------------------------------------------
module tb_button_reset_gen;

    localparam int D   = 4;
    localparam int DBW = 3;
    localparam int R   = 3;

`ifdef BTN_RST_POR_EN
    localparam bit POR = 1'b1;
`else
    localparam bit POR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic cnt_rst_n;
    logic pressed;
    logic press_pulse;
    logic busy;

    always #5 clk = ~clk;

    button_reset_gen #(
        .DEBOUNCE_CYCLES(D),
        .DB_W(DBW),
        .RST_CYCLES(R)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .cnt_rst_n(cnt_rst_n),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: synchroniser as a two-deep delay line, debounce as
    // a run length of disagreeing samples, reset pulse as a countdown of
    // remaining low cycles plus a "wait for release" flag.
    bit m_s1, m_s2;
    int m_run;
    bit m_pressed;
    bit m_pulse;
    int m_low_left;
    bit m_wait;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1       = 1'b0;
        m_s2       = 1'b0;
        m_run      = 0;
        m_pressed  = 1'b0;
        m_pulse    = 1'b0;
        m_low_left = POR ? R : 0;
        m_wait     = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic r);
        bit old_s2, old_pressed, old_pulse;
        if (!r) begin
            model_reset();
        end else begin
            old_s2      = m_s2;
            old_pressed = m_pressed;
            old_pulse   = m_pulse;
            m_s2        = m_s1;
            m_s1        = b;
            m_pulse     = 1'b0;
            if (old_s2 != old_pressed) begin
                m_run++;
                if (m_run == D) begin
                    m_pressed = !old_pressed;
                    m_pulse   = m_pressed;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_low_left > 0) begin
                m_low_left--;
                if (m_low_left == 0) m_wait = old_pressed;
            end else if (m_wait) begin
                if (!old_pressed) m_wait = 1'b0;
            end else if (old_pulse) begin
                m_low_left = R;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cnt_rst_n"},   cnt_rst_n,   m_low_left == 0);
        chk({tag, ".busy"},        busy,        m_low_left > 0);
        chk({tag, ".pressed"},     pressed,     m_pressed);
        chk({tag, ".press_pulse"}, press_pulse, m_pulse);
    endtask

    // Drive btn, take one clock edge, advance the model, compare 1 ns later.
    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        model_edge(b, rst);
        #1;
        check_model("model");
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".pressed"},     pressed,     1'b0);
        chk({tag, ".press_pulse"}, press_pulse, 1'b0);
        chk({tag, ".cnt_rst_n"},   cnt_rst_n,   !POR);
        chk({tag, ".busy"},        busy,        POR);
    endtask

    // Assert rst between edges, check the asynchronous effect, hold it for
    // some cycles, then release it 1 ns after an edge.
    task automatic async_reset(input int cyc);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_rst");
        check_model("async_rst");
        for (int i = 0; i < cyc; i++) step(1'b0);
        rst = 1'b1;
    endtask

    task automatic power_on_checks(input string tag);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0);
            chk({tag, ".cnt_rst_n"}, cnt_rst_n, POR ? (k >= 3) : 1'b1);
            chk({tag, ".pressed"},   pressed,   1'b0);
        end
    endtask

    // Button held from edge E0: strobe after E5, counter reset low after
    // E6..E8, released after E9, no further strobe.
    task automatic press_checks(input string tag, input int len);
        for (int k = 0; k < len; k++) begin
            step(1'b1);
            chk({tag, ".press_pulse"}, press_pulse, k == 5);
            chk({tag, ".pressed"},     pressed,     k >= 5);
            chk({tag, ".cnt_rst_n"},   cnt_rst_n,   !(k >= 6 && k <= 8));
            chk({tag, ".busy"},        busy,        k >= 6 && k <= 8);
        end
    endtask

    task automatic quiet_checks(input string tag, input logic b);
        step(b);
        chk({tag, ".pressed"},     pressed,     1'b0);
        chk({tag, ".press_pulse"}, press_pulse, 1'b0);
        chk({tag, ".cnt_rst_n"},   cnt_rst_n,   1'b1);
    endtask

    initial begin
        int lvl;
        int len;

        // Reset state
        rst = 1'b0;
        btn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // Power-on behaviour after release
        power_on_checks("power_on");

        // Clean press held for 20 cycles
        press_checks("press", 20);

        // Release: pressed falls after E5 of the release
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            chk("release.pressed",     pressed,     k < 5);
            chk("release.press_pulse", press_pulse, 1'b0);
            chk("release.cnt_rst_n",   cnt_rst_n,   1'b1);
        end

        // Re-press gives a second pulse, then release again
        press_checks("repress", 12);
        for (int k = 0; k < 10; k++) step(1'b0);

        // Bounce 1,0,1,0 then settle low
        quiet_checks("bounce", 1'b1);
        quiet_checks("bounce", 1'b0);
        quiet_checks("bounce", 1'b1);
        quiet_checks("bounce", 1'b0);
        for (int k = 0; k < 10; k++) quiet_checks("bounce", 1'b0);

        // Short hold: one cycle shy of acceptance
        for (int k = 0; k < 3; k++) quiet_checks("short", 1'b1);
        for (int k = 0; k < 10; k++) quiet_checks("short", 1'b0);

        // Reset on the second HOLD cycle
        for (int k = 0; k <= 7; k++) begin
            step(1'b1);
            if (k >= 6) chk("midhold.cnt_rst_n", cnt_rst_n, 1'b0);
        end
        async_reset(2);
        power_on_checks("after_rst");

        // Randomized runs of button levels with occasional async resets
        for (int n = 0; n < 120; n++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) step(lvl[0]);
            if ($urandom_range(0, 29) == 0) async_reset(int'($urandom_range(1, 3)));
        end
        for (int k = 0; k < 12; k++) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_reset_gen.md
# button_reset_gen

Upstream stage of the free-running binary counter on the WireFrame board (XC3S250E, 25 MHz clock). It synchronises and debounces a raw pushbutton and produces a clean, fixed-width, active-low synchronous reset pulse for the counter's `rst` input. It also exports the debounced button level and a one-cycle press strobe for other consumers.

## Interface
- `DEBOUNCE_CYCLES`, default 250000, is the number of consecutive stable cycles needed to accept a button change (10 ms at 25 MHz). Legal range is 1 to 2^`DB_W`-1.
- `DB_W`, default 18, is the width of the debounce counter.
- `RST_CYCLES`, default 16, is the number of cycles `cnt_rst_n` is held low per event. Legal range is 1 to 255.
- `clk`, input, 1 bit: the on-board 25 MHz clock. All logic is on `posedge clk`.
- `rst`, input, 1 bit: asynchronous, active-low reset of this block. One clock; reset is asynchronous and active-low.
- `btn`, input, 1 bit: raw pushbutton, asynchronous, bouncy. 1 means pressed.
- `cnt_rst_n`, output, 1 bit: registered active-low reset for the downstream counter.
- `pressed`, output, 1 bit: debounced button level.
- `press_pulse`, output, 1 bit: one-cycle strobe on each accepted press.
- `busy`, output, 1 bit: high while `cnt_rst_n` is asserted (low).

## Operation
- **Synchroniser:** `btn` passes through 2 flops to give `btn_s`. Nothing else samples `btn`.
- **Debouncer:**
  - When `btn_s == pressed`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while `btn_s != pressed`, `pressed` toggles on that edge and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles causes no change.
- **`press_pulse`:** high for exactly the one cycle in which `pressed` is 1 for the first time, i.e. a 0→1 transition. A release produces no pulse.
- **FSM** (states IDLE, HOLD, WAIT_REL) and hold counter `hc` (8 bits):
  - IDLE: when `press_pulse` is 1, set `hc`=0 and go to HOLD. Otherwise stay.
  - HOLD: `hc` increments each cycle. When `hc == RST_CYCLES-1`, go to WAIT_REL if `pressed`=1, otherwise to IDLE.
  - WAIT_REL: go to IDLE when `pressed`=0.
- **Outputs:** `cnt_rst_n` = !(state==HOLD) and `busy` = (state==HOLD), both registered from the next-state decode.
- **Boundary cases:**
  - A press accepted while in HOLD or WAIT_REL is ignored. There is no re-trigger and HOLD is not extended.
  - Holding the button produces exactly one reset pulse. A new pulse needs a debounced release followed by a new press.
  - `rst` asserted mid-HOLD or mid-debounce aborts immediately. All state takes its reset values.
- **Reset values, while `rst`=0:**
  - Synchroniser flops, debounce counter and `hc` are 0.
  - `pressed`=0 and `press_pulse`=0.
  - State, `cnt_rst_n` and `busy` depend on `BTN_RST_POR_EN` (see Configuration).

## Timing
- **`btn`→`pressed` latency:** `btn` rises before edge E0 and stays stable. `btn_s`=1 after edge E1. `pressed` and `press_pulse` are 1 after edge E1+`DEBOUNCE_CYCLES`.
- **`press_pulse`→`cnt_rst_n` latency:** `cnt_rst_n` goes low at the edge after `press_pulse` is sampled high. It stays low for exactly `RST_CYCLES` cycles, then returns high.
- **Release latency:** `pressed` falls `DEBOUNCE_CYCLES+2` edges after a stable release.
- **Counter interface:** the counter samples `cnt_rst_n` synchronously. With `RST_CYCLES`≥1 it sees at least one low sample per event.

## Configuration
- Macro: `BTN_RST_POR_EN`.
- **Defined:**
  - During `rst`=0, the state is HOLD with `hc`=0, `cnt_rst_n`=0 and `busy`=1.
  - After `rst` deasserts, `cnt_rst_n` stays low for `RST_CYCLES` cycles. This is the power-on reset of the counter.
- **Undefined:**
  - During `rst`=0, the state is IDLE with `cnt_rst_n`=1 and `busy`=0.
  - No pulse is generated until the first debounced press.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DB_W`=3, `RST_CYCLES`=3.
1. **Power-on, macro defined:** release `rst` with `btn`=0. `cnt_rst_n`=0 for exactly 3 cycles after release, then 1. `pressed`=0. Without the macro, `cnt_rst_n`=1 throughout.
2. **Clean press:** raise `btn` before E0 and hold it for 20 cycles. `press_pulse`=1 only after E5. `cnt_rst_n`=0 after E6, E7 and E8, then 1 after E9. No second pulse while held.
3. **Bounce:** `btn` toggles 1,0,1,0 on successive cycles and then holds 0. `pressed` never rises and `cnt_rst_n` stays 1.
4. **Release and re-press:** from pressed, `btn`=0 for 10 cycles, then `btn`=1. `pressed` falls 6 edges after release. A second 3-cycle `cnt_rst_n` pulse follows the second `press_pulse`.
5. **Reset mid-HOLD:** assert `rst` on the 2nd HOLD cycle. All outputs jump to their reset values asynchronously. After deassert, behaviour matches scenario 1.
6. **Short hold:** `btn` held for exactly 3 stable cycles, then 0. No `press_pulse` and `cnt_rst_n`=1.
